// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter with an internal byte
//                FIFO. The CPU pushes bytes at offset 0x0, clears the sticky
//                overflow flag with any write to offset 0x4, and polls a
//                combinational STATUS word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        full_o,
   output logic        busy_o,
   output logic        txd_o
);

   // Clocks per serial bit, and the widths derived from the parameters.
   localparam int c_DIV = CLK_FREQ / BAUD;
   localparam int c_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW  = c_AW + 1;
   localparam int c_BW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;

   localparam logic [c_BW-1:0] c_BAUD_RELOAD = c_BW'(c_DIV - 1);
   localparam logic [c_CW-1:0] c_FULL_COUNT  = c_CW'(FIFO_DEPTH);
   localparam logic [3:0]      c_ADDR_TXDATA = 4'h0;
   localparam logic [3:0]      c_ADDR_STATUS = 4'h4;
   localparam logic [2:0]      c_LAST_BIT    = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_CW-1:0] r_count;
   logic            r_ovf;

   // Transmitter state
   state_t          r_state;
   logic [c_BW-1:0] r_baud;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_sh;
   logic            r_txd;

   // Combinational decode
   logic            w_full;
   logic            w_empty;
   logic            w_busy;
   logic            w_push_req;
   logic            w_push;
   logic            w_pop;
   logic            w_clr;
   logic            w_baud_done;
   logic [7:0]      w_count8;
   logic            w_unused_wdata;

   // Only the low byte of a TXDATA write is carried into the FIFO.
   assign w_unused_wdata = ^wdata_i[31:8];

   // Full/empty come from the pre-edge count, so a push while full is
   // dropped even when the transmitter pops in the same cycle.
   assign w_full      = (r_count == c_FULL_COUNT);
   assign w_empty     = (r_count == '0);
   assign w_push_req  = we_i && (addr_i == c_ADDR_TXDATA);
   assign w_push      = w_push_req && !w_full;
   assign w_clr       = we_i && (addr_i == c_ADDR_STATUS);
   assign w_pop       = (r_state == S_IDLE) && !w_empty;
   assign w_busy      = (r_state != S_IDLE) || !w_empty;
   assign w_baud_done = (r_baud == '0);
   assign w_count8    = 8'(r_count);

   assign rdata_o = {16'h0000, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
   assign full_o  = w_full;
   assign busy_o  = w_busy;
   assign txd_o   = r_txd;

   // FIFO data array: written on an accepted push, no reset needed.
   always_ff @(posedge clk_i) begin
      if (rst_ni && w_push) begin
         r_mem[r_wptr] <= wdata_i[7:0];
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full) begin
            r_ovf <= 1'b1;
         end else if (w_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Frame serialiser: start bit, 8 data bits LSB first, stop bit, each
   // held for c_DIV clocks; the line level is registered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_sh      <= '0;
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_sh    <= r_mem[r_rptr];
                  r_baud  <= c_BAUD_RELOAD;
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_done) begin
                  r_baud    <= c_BAUD_RELOAD;
                  r_bit_idx <= '0;
                  r_txd     <= r_sh[0];
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_done) begin
                  r_baud <= c_BAUD_RELOAD;
                  if (r_bit_idx == c_LAST_BIT) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_sh      <= {1'b0, r_sh[7:1]};
                     r_txd     <= r_sh[1];
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_done) begin
                  r_txd   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_baud <= r_baud - 1'b1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx (DIV=4, depth 4).
//                A queue-based reference model predicts the line and status
//                every cycle; hand tables and sequences cover corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

   localparam int c_DIV   = 4;
   localparam int c_DEPTH = 4;

   logic        clk;
   logic        rst_ni;
   logic        we_i;
   logic [3:0]  addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        full_o;
   logic        busy_o;
   logic        txd_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_active;
   int         m_el;
   logic [7:0] m_cur;
   bit         m_ovf;

   logic       line_log[$];

   mmio_uart_tx #(
      .CLK_FREQ   (40),
      .BAUD       (10),
      .FIFO_DEPTH (c_DEPTH)
   ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .full_o  (full_o),
      .busy_o  (busy_o),
      .txd_o   (txd_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_edge(input logic rst_n, input logic we, input logic [3:0] addr,
                             input logic [31:0] wdata);
      bit pre_full;
      bit pre_nonempty;
      bit pre_idle;
      if (!rst_n) begin
         q.delete();
         m_active = 0;
         m_el     = 0;
         m_ovf    = 0;
         return;
      end
      pre_full     = (q.size() == c_DEPTH);
      pre_nonempty = (q.size() != 0);
      pre_idle     = !m_active;
      if (pre_idle && pre_nonempty) begin
         m_cur    = q.pop_front();
         m_active = 1;
         m_el     = 0;
      end else if (m_active) begin
         m_el++;
         if (m_el == 10 * c_DIV) m_active = 0;
      end
      if (we && addr == 4'h0) begin
         if (pre_full) m_ovf = 1;
         else q.push_back(wdata[7:0]);
      end else if (we && addr == 4'h4) begin
         m_ovf = 0;
      end
   endtask

   function automatic logic model_txd();
      int b;
      if (!m_active) return 1'b1;
      b = m_el / c_DIV;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_rdata();
      logic full;
      logic empty;
      logic busy;
      full  = (q.size() == c_DEPTH);
      empty = (q.size() == 0);
      busy  = m_active || !empty;
      return {16'h0, 8'(q.size()), 4'h0, m_ovf, busy, empty, full};
   endfunction

   // Apply one cycle of bus inputs, advance the model, compare after the edge.
   task automatic step(input logic rst_n, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata);
      logic [31:0] exp_rd;
      rst_ni  = rst_n;
      we_i    = we;
      addr_i  = addr;
      wdata_i = wdata;
      @(posedge clk);
      model_edge(rst_n, we, addr, wdata);
      #1;
      we_i   = 1'b0;
      rst_ni = 1'b1;
      exp_rd = model_rdata();
      line_log.push_back(txd_o);
      chk("model_txd",   32'(txd_o),  32'(model_txd()));
      chk("model_rdata", rdata_o,     exp_rd);
      chk("model_full",  32'(full_o), 32'(exp_rd[0]));
      chk("model_busy",  32'(busy_o), 32'(exp_rd[2]));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'h0, 32'h0);
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_txd;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [9:0] fr;
      logic [7:0] b;
      int         nf;
      int         last;

      clk     = 1'b0;
      rst_ni  = 1'b0;
      we_i    = 1'b0;
      addr_i  = 4'h0;
      wdata_i = 32'h0;
      m_active = 0; m_el = 0; m_cur = 8'h0; m_ovf = 0;

      // Post-edge expectations, starting from an empty, idle block.
      tbl[0] = '{1'b1, 4'h8, 32'h000000FF, 32'h00000002, 1'b1};
      tbl[1] = '{1'b1, 4'h4, 32'h00000000, 32'h00000002, 1'b1};
      tbl[2] = '{1'b1, 4'h0, 32'h00000141, 32'h00000104, 1'b1};
      tbl[3] = '{1'b0, 4'h0, 32'h00000000, 32'h00000006, 1'b0};
      tbl[4] = '{1'b1, 4'h0, 32'h00000055, 32'h00000104, 1'b0};
      tbl[5] = '{1'b1, 4'hC, 32'h00000066, 32'h00000104, 1'b0};
      tbl[6] = '{1'b0, 4'h0, 32'h00000000, 32'h00000104, 1'b0};
      tbl[7] = '{1'b0, 4'h0, 32'h00000000, 32'h00000104, 1'b1};

      // Reset, including a write that must be ignored while held in reset.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      step(1'b0, 1'b1, 4'h0, 32'hAA);
      chk("reset_rdata", rdata_o, 32'h00000002);
      chk("reset_txd",   32'(txd_o), 32'h1);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         chk("tbl_rdata", rdata_o, tbl[i].exp_rdata);
         chk("tbl_txd",   32'(txd_o), 32'(tbl[i].exp_txd));
      end

      // Single byte 0x41: exact line waveform and busy release at N+41.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      step(1'b1, 1'b1, 4'h0, 32'h41);
      fr = {1'b1, 8'h41, 1'b0};
      for (int k = 1; k <= 41; k++) begin
         idle(1);
         if (k <= 40) chk("sb_txd", 32'(txd_o), 32'(fr[(k-1)/c_DIV]));
         chk("sb_busy", 32'(busy_o), (k < 41) ? 32'h1 : 32'h0);
      end
      chk("sb_status", rdata_o, 32'h00000002);

      // Burst fill: sixth write is dropped, then the overflow flag is cleared.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      line_log.delete();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h0, 32'h30 + 32'(i));
      chk("burst_status", rdata_o, 32'h0000040D);
      step(1'b1, 1'b1, 4'h4, 32'h0);
      chk("ovf_clear", 32'(rdata_o[3]), 32'h0);
      idle(205);
      chk("burst_done", rdata_o, 32'h00000002);
      nf   = 0;
      last = 0;
      for (int i = 1; i < line_log.size(); i++) begin
         if (line_log[i-1] == 1'b1 && line_log[i] == 1'b0 && (i + 34) < line_log.size()) begin
            for (int j = 0; j < 8; j++) b[j] = line_log[i + c_DIV*(j+1) + 2];
            chk("burst_byte", 32'(b), 32'h30 + 32'(nf));
            if (nf > 0) chk("burst_spacing", 32'(i - last), 32'd41);
            last = i;
            nf++;
            i += 39;
         end
      end
      chk("burst_frames", 32'(nf), 32'd5);

      // Reset during data bit 3 with another byte still queued.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      step(1'b1, 1'b1, 4'h0, 32'h5A);
      step(1'b1, 1'b1, 4'h0, 32'hC3);
      idle(16);
      step(1'b0, 1'b1, 4'h0, 32'h77);
      chk("rst_mid_txd",   32'(txd_o), 32'h1);
      chk("rst_mid_rdata", rdata_o, 32'h00000002);
      for (int k = 0; k < 60; k++) begin
         idle(1);
         chk("rst_quiet", 32'(txd_o), 32'h1);
      end

      // Push coinciding with the IDLE pop while two bytes are queued.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      step(1'b1, 1'b1, 4'h0, 32'h11);
      idle(1);
      step(1'b1, 1'b1, 4'h0, 32'h22);
      step(1'b1, 1'b1, 4'h0, 32'h33);
      idle(38);
      chk("pp_count_before", 32'(rdata_o[15:8]), 32'd2);
      step(1'b1, 1'b1, 4'h0, 32'h44);
      chk("pp_count_after", 32'(rdata_o[15:8]), 32'd2);
      chk("pp_no_ovf",      32'(rdata_o[3]), 32'h0);

      // Randomised traffic against the model.
      step(1'b0, 1'b0, 4'h0, 32'h0);
      for (int k = 0; k < 3000; k++) begin
         logic       r_rst;
         logic       r_we;
         logic [3:0] r_addr;
         r_rst = ($urandom_range(0, 299) != 0);
         r_we  = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0, 1:    r_addr = 4'h0;
            2:       r_addr = 4'h4;
            default: r_addr = 4'($urandom_range(0, 15));
         endcase
         step(r_rst, r_we, r_addr, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
